// File: rtl/sdram_burst_mover.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_burst_mover
//  Purpose  : Avalon-MM burst DMA engine; copies or fills LEN words through
//             one shared master port, reporting done and a cycle count.
//  Revision : 1.0  initial release
// ============================================================================
module sdram_burst_mover #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 8,
    parameter int BC_W      = 4
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              start,
    input  logic              mode_fill,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic [31:0]       cycle_count,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [BC_W-1:0]   avm_burstcount,
    output logic              avm_beginbursttransfer,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_rd_cmd   = 3'd1;
    localparam logic [2:0] c_st_rd_data  = 3'd2;
    localparam logic [2:0] c_st_wr_burst = 3'd3;
    localparam logic [2:0] c_st_finish   = 3'd4;

    localparam int                c_idx_w   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [LEN_W-1:0]  c_max_len = LEN_W'(MAX_BURST);
    localparam logic [ADDR_W-1:0] c_bytes   = ADDR_W'(DATA_W / 8);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic              r_mode_fill;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [LEN_W-1:0]  r_remaining;
    logic [DATA_W-1:0] r_fill_data;
    logic [BC_W-1:0]   r_rd_cnt;
    logic [BC_W-1:0]   r_wr_cnt;
    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_cycle_count;
    logic [ADDR_W-1:0] r_avm_address;
    logic              r_avm_read;
    logic              r_avm_write;
    logic [BC_W-1:0]   r_avm_burstcount;
    logic              r_avm_begin;
    logic [DATA_W-1:0] r_avm_writedata;
    logic [DATA_W-1:0] r_buf [MAX_BURST];

    logic [BC_W-1:0]    w_burst;
    logic               w_last_rd;
    logic               w_last_wr;
    logic [LEN_W-1:0]   w_rem_next;
    logic [ADDR_W-1:0]  w_step;
    logic [c_idx_w-1:0] w_wr_next_idx;

    // Burst length only changes when remaining changes, i.e. at the end of a write burst.
    assign w_burst       = (r_remaining > c_max_len) ? BC_W'(MAX_BURST) : r_remaining[BC_W-1:0];
    assign w_last_rd     = (r_rd_cnt == w_burst - BC_W'(1));
    assign w_last_wr     = (r_wr_cnt == w_burst - BC_W'(1));
    assign w_rem_next    = r_remaining - LEN_W'(w_burst);
    assign w_step        = ADDR_W'(w_burst) * c_bytes;
    assign w_wr_next_idx = r_wr_cnt[c_idx_w-1:0] + c_idx_w'(1);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    if (len_words == '0) begin
                        w_next_state = c_st_finish;
                    end else if (mode_fill) begin
                        w_next_state = c_st_wr_burst;
                    end else begin
                        w_next_state = c_st_rd_cmd;
                    end
                end
            end
            c_st_rd_cmd: begin
                if (r_avm_read && !avm_waitrequest) begin
                    w_next_state = c_st_rd_data;
                end
            end
            c_st_rd_data: begin
                if (avm_readdatavalid && w_last_rd) begin
                    w_next_state = c_st_wr_burst;
                end
            end
            c_st_wr_burst: begin
                if (r_avm_write && !avm_waitrequest && w_last_wr) begin
                    if (w_rem_next != '0) begin
                        w_next_state = r_mode_fill ? c_st_wr_burst : c_st_rd_cmd;
                    end else begin
                        w_next_state = c_st_finish;
                    end
                end
            end
            c_st_finish: w_next_state = c_st_idle;
            default:     w_next_state = c_st_idle;
        endcase
    end

    // Read-data buffer; emptiness is tracked by the counters, so contents need no reset.
    always_ff @(posedge clk_clk) begin
        if (reset_reset_n && (r_state == c_st_rd_data) && avm_readdatavalid) begin
            r_buf[r_rd_cnt[c_idx_w-1:0]] <= avm_readdata;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_mode_fill      <= 1'b0;
            r_rd_ptr         <= '0;
            r_wr_ptr         <= '0;
            r_remaining      <= '0;
            r_fill_data      <= '0;
            r_rd_cnt         <= '0;
            r_wr_cnt         <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_cycle_count    <= '0;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_burstcount <= '0;
            r_avm_begin      <= 1'b0;
            r_avm_writedata  <= '0;
        end else begin
            r_avm_begin <= 1'b0;
            if (r_busy && (r_cycle_count != '1)) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_mode_fill   <= mode_fill;
                        r_rd_ptr      <= src_addr;
                        r_wr_ptr      <= dst_addr;
                        r_remaining   <= len_words;
                        r_fill_data   <= fill_data;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_cycle_count <= '0;
                    end
                end
                c_st_rd_cmd: begin
                    if (!r_avm_read) begin
                        r_avm_read       <= 1'b1;
                        r_avm_address    <= r_rd_ptr;
                        r_avm_burstcount <= w_burst;
                        r_avm_begin      <= 1'b1;
                        r_rd_cnt         <= '0;
                    end else if (!avm_waitrequest) begin
                        r_avm_read <= 1'b0;
                    end
                end
                c_st_rd_data: begin
                    if (avm_readdatavalid) begin
                        r_rd_cnt <= r_rd_cnt + BC_W'(1);
                    end
                end
                c_st_wr_burst: begin
                    if (!r_avm_write) begin
                        r_avm_write      <= 1'b1;
                        r_avm_address    <= r_wr_ptr;
                        r_avm_burstcount <= w_burst;
                        r_avm_begin      <= 1'b1;
                        r_avm_writedata  <= r_mode_fill ? r_fill_data : r_buf[0];
                        r_wr_cnt         <= '0;
                    end else if (!avm_waitrequest) begin
                        if (w_last_wr) begin
                            r_avm_write <= 1'b0;
                            r_remaining <= w_rem_next;
                            r_rd_ptr    <= r_rd_ptr + w_step;
                            r_wr_ptr    <= r_wr_ptr + w_step;
                        end else begin
                            r_wr_cnt        <= r_wr_cnt + BC_W'(1);
                            r_avm_writedata <= r_mode_fill ? r_fill_data : r_buf[w_wr_next_idx];
                        end
                    end
                end
                c_st_finish: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy                   = r_busy;
    assign done                   = r_done;
    assign cycle_count            = r_cycle_count;
    assign avm_address            = r_avm_address;
    assign avm_read               = r_avm_read;
    assign avm_write              = r_avm_write;
    assign avm_burstcount         = r_avm_burstcount;
    assign avm_beginbursttransfer = r_avm_begin;
    assign avm_writedata          = r_avm_writedata;

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_mover.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_burst_mover
//  Purpose  : Directed self-checking bench with a small Avalon slave model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_burst_mover;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode_fill = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] len_words = '0;
    logic [15:0] fill_data = '0;
    logic        busy, done;
    logic [31:0] cycle_count;
    logic [31:0] avm_address;
    logic        avm_read, avm_write, avm_begin;
    logic [3:0]  avm_burstcount;
    logic [15:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic [15:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;

    int tests = 0;
    int failed = 0;

    sdram_burst_mover dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .mode_fill(mode_fill),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words), .fill_data(fill_data),
        .busy(busy), .done(done), .cycle_count(cycle_count),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_burstcount(avm_burstcount), .avm_beginbursttransfer(avm_begin),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clk = ~clk;

    // Slave model and bus monitor, evaluated on the falling edge.
    int          wait_mode = 0;
    int          rd_pending = 0;
    logic [31:0] rd_word = '0;
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];
    logic [31:0] wb_addr_log [8];
    logic [31:0] wb_bc_log [8];
    logic [31:0] rb_addr_log [8];
    logic [31:0] rb_bc_log [8];
    int wr_n = 0, wr_bursts = 0, rd_bursts = 0, rd_active = 0, act_cnt = 0;
    int overlap_cnt = 0, stall_bad = 0;
    logic        p_stall = 1'b0, p_read = 1'b0, p_write = 1'b0;
    logic [31:0] p_addr = '0;
    logic [3:0]  p_bc = '0;
    logic [15:0] p_wd = '0;

    always @(negedge clk) begin
        if (rst_n && p_stall) begin
            if (avm_read !== p_read || avm_write !== p_write || avm_address !== p_addr ||
                avm_burstcount !== p_bc || (p_write && avm_writedata !== p_wd))
                stall_bad++;
        end
        if (rd_pending > 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = rd_word[15:0];
            rd_word++;
            rd_pending--;
        end else begin
            avm_readdatavalid = 1'b0;
        end
        case (wait_mode)
            1:       avm_waitrequest = 1'($urandom_range(0, 1));
            2:       avm_waitrequest = 1'b1;
            default: avm_waitrequest = 1'b0;
        endcase
        if (rst_n) begin
            if (avm_read || avm_write) act_cnt++;
            if (avm_read) rd_active++;
            if (avm_read && avm_write) overlap_cnt++;
            if (avm_read && avm_begin && rd_bursts < 8) begin
                rb_addr_log[rd_bursts] = avm_address;
                rb_bc_log[rd_bursts]   = 32'(avm_burstcount);
                rd_bursts++;
            end
            if (avm_write && avm_begin && wr_bursts < 8) begin
                wb_addr_log[wr_bursts] = avm_address;
                wb_bc_log[wr_bursts]   = 32'(avm_burstcount);
                wr_bursts++;
            end
            if (avm_read && !avm_waitrequest) begin
                rd_pending = int'(avm_burstcount);
                rd_word    = avm_address >> 1;
            end
            if (avm_write && !avm_waitrequest && wr_n < 64) begin
                wr_addr_log[wr_n] = avm_address;
                wr_data_log[wr_n] = 32'(avm_writedata);
                wr_n++;
            end
        end
        p_stall = (avm_read || avm_write) && avm_waitrequest;
        p_read  = avm_read;
        p_write = avm_write;
        p_addr  = avm_address;
        p_bc    = avm_burstcount;
        p_wd    = avm_writedata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_n = 0; wr_bursts = 0; rd_bursts = 0; rd_active = 0; act_cnt = 0;
        overlap_cnt = 0; stall_bad = 0; rd_pending = 0;
    endtask

    // Called on a falling edge; returns on the falling edge after the start edge.
    task automatic do_start(input logic fill, input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input logic [15:0] pat);
        mode_fill = fill; src_addr = src; dst_addr = dst; len_words = len; fill_data = pat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) check("done_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cc", 64'(cycle_count), 64'd0);
        check("rst_rdwr", 64'({avm_read, avm_write, avm_begin}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: copy 8 words, zero-wait; request latency and single bursts
        clear_logs();
        do_start(1'b0, 32'h0, 32'h1000, 16'd8, 16'h0);
        check("t1_busy_after_start", 64'(busy), 64'd1);
        check("t1_read_not_yet", 64'(avm_read), 64'd0);
        @(negedge clk);
        check("t1_read_second_edge", 64'({avm_read, avm_begin, avm_burstcount}), 64'({1'b1, 1'b1, 4'd8}));
        wait_done(200);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_cc", 64'(cycle_count), 64'd20);
        check("t1_bursts", 64'({rd_bursts[7:0], wr_bursts[7:0]}), 64'h0101);
        check("t1_rd_bc", 64'(rb_bc_log[0]), 64'd8);
        check("t1_wr_bc", 64'(wb_bc_log[0]), 64'd8);
        check("t1_beats", 64'(wr_n), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("t1_waddr", 64'(wr_addr_log[i]), 64'h1000);
            check("t1_wdata", 64'(wr_data_log[i]), 64'(i));
        end

        // 2: copy 19 words -> bursts 8, 8, 3
        clear_logs();
        do_start(1'b0, 32'h0, 32'h1000, 16'd19, 16'h0);
        wait_done(500);
        check("t2_beats", 64'(wr_n), 64'd19);
        check("t2_bursts", 64'({rd_bursts[7:0], wr_bursts[7:0]}), 64'h0303);
        for (int k = 0; k < 3; k++) begin
            check("t2_rb_addr", 64'(rb_addr_log[k]), 64'(k * 16));
            check("t2_rb_bc", 64'(rb_bc_log[k]), (k < 2) ? 64'd8 : 64'd3);
            check("t2_wb_addr", 64'(wb_addr_log[k]), 64'(32'h1000 + k * 16));
            check("t2_wb_bc", 64'(wb_bc_log[k]), (k < 2) ? 64'd8 : 64'd3);
        end
        for (int i = 0; i < 19; i++) begin
            check("t2_waddr", 64'(wr_addr_log[i]), 64'(32'h1000 + (i / 8) * 16));
            check("t2_wdata", 64'(wr_data_log[i]), 64'(i));
        end
        check("t2_no_overlap", 64'(overlap_cnt), 64'd0);

        // 3: fill with random waitrequest
        clear_logs();
        wait_mode = 1;
        do_start(1'b1, 32'h0, 32'h200, 16'd5, 16'hA5A5);
        wait_done(500);
        wait_mode = 0;
        check("t3_no_read", 64'(rd_active), 64'd0);
        check("t3_beats", 64'(wr_n), 64'd5);
        check("t3_wb_bc", 64'(wb_bc_log[0]), 64'd5);
        for (int i = 0; i < 5; i++) begin
            check("t3_waddr", 64'(wr_addr_log[i]), 64'h200);
            check("t3_wdata", 64'(wr_data_log[i]), 64'hA5A5);
        end
        check("t3_stall_stable", 64'(stall_bad), 64'd0);

        // 4: zero length
        clear_logs();
        do_start(1'b0, 32'h0, 32'h1000, 16'd0, 16'h0);
        check("t4_busy", 64'({busy, done}), 64'b10);
        @(negedge clk);
        check("t4_done", 64'({busy, done}), 64'b01);
        check("t4_cc", 64'(cycle_count), 64'd1);
        check("t4_no_bus", 64'(act_cnt), 64'd0);

        // 5: start while busy ignored, then reset mid write burst
        clear_logs();
        do_start(1'b0, 32'h0, 32'h1000, 16'd8, 16'h0);
        repeat (2) @(negedge clk);
        do_start(1'b1, 32'h0, 32'h3000, 16'd3, 16'h5555);
        check("t5_busy_kept", 64'(busy), 64'd1);
        for (int n = 0; n < 100 && avm_write !== 1'b1; n++) @(negedge clk);
        check("t5_write_seen", 64'(avm_write), 64'd1);
        check("t5_addr_orig", 64'(avm_address), 64'h1000);
        check("t5_data_copy", 64'(avm_writedata), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_outs", 64'({avm_write, avm_read, busy, done}), 64'd0);
        check("t5_rst_cc", 64'(cycle_count), 64'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_no_done", 64'({busy, done}), 64'd0);

        // 6: destination pointer wraps
        clear_logs();
        do_start(1'b0, 32'h40, 32'hFFFF_FFFC, 16'd4, 16'h0);
        wait_done(200);
        check("t6_wb_addr", 64'(wb_addr_log[0]), 64'hFFFF_FFFC);
        check("t6_wb_bc", 64'(wb_bc_log[0]), 64'd4);
        for (int i = 0; i < 4; i++) check("t6_wdata", 64'(wr_data_log[i]), 64'(32'h20 + i));
        clear_logs();
        do_start(1'b0, 32'h40, 32'hFFFF_FFFC, 16'd12, 16'h0);
        wait_done(400);
        check("t6b_bursts", 64'(wr_bursts), 64'd2);
        check("t6b_wrap_addr", 64'(wb_addr_log[1]), 64'h0000_000C);
        check("t6b_bc", 64'(wb_bc_log[1]), 64'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_burst_mover.md
Name: sdram_burst_mover

Overview:
Parametrised Avalon-MM burst DMA engine that supersedes the fixed start/done SDRAM burst hook on the HPS system. On a start pulse it moves LEN words from SRC to DST in bursts of up to MAX_BURST words, using one shared Avalon-MM master port into the SDRAM controller. In FILL mode it writes a constant pattern instead of copying. It asserts done and exposes a 32-bit cycle count for the hex/LED readout.

Parameters:
DATA_W, 16, Avalon data width in bits; must be a multiple of 8.
ADDR_W, 32, byte-address width.
LEN_W, 16, word-count width.
MAX_BURST, 8, maximum burst length in words; power of 2, at most 64.
BC_W, 4, burstcount width; must be at least log2(MAX_BURST)+1.

Ports:
clk_clk  in  1  single clock for all logic.
reset_reset_n  in  1  synchronous, active-low reset.
start  in  1  one-cycle start pulse; sampled only in IDLE.
mode_fill  in  1  0 = copy, 1 = fill; latched at start.
src_addr  in  ADDR_W  source byte address; latched at start.
dst_addr  in  ADDR_W  destination byte address; latched at start.
len_words  in  LEN_W  number of words to move; latched at start.
fill_data  in  DATA_W  pattern used in fill mode; latched at start.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  level; set at completion, cleared by the next accepted start.
cycle_count  out  32  cycles from accepted start to done; saturates at 0xFFFFFFFF.
avm_address  out  ADDR_W  byte address.
avm_read  out  1  read request.
avm_write  out  1  write request.
avm_burstcount  out  BC_W  burst length.
avm_beginbursttransfer  out  1  high on the first cycle of each burst command.
avm_writedata  out  DATA_W  write data.
avm_waitrequest  in  1  slave stall.
avm_readdata  in  DATA_W  read data.
avm_readdatavalid  in  1  read data valid.

Behaviour:
- Reset, while reset_reset_n = 0 at a clock edge: all outputs go to 0, FSM goes to IDLE, and the internal buffer is emptied. Reset mid-transfer aborts immediately. avm_read/avm_write are low from the first edge with reset asserted, and no done is produced.
- FSM states:
  - IDLE: on start, latch inputs, set busy, clear done, zero cycle_count. If len = 0, go to FINISH. Otherwise go to RD_CMD in copy mode, or WR_BURST in fill mode.
  - RD_CMD: B = min(MAX_BURST, remaining). Hold avm_read = 1, avm_address = rd_ptr and avm_burstcount = B until waitrequest = 0. avm_beginbursttransfer is high only on the first cycle of the command. Then go to RD_DATA.
  - RD_DATA: each readdatavalid pushes readdata into a MAX_BURST-entry buffer. After B beats, go to WR_BURST. readdatavalid outside RD_DATA is ignored.
  - WR_BURST: hold avm_write = 1 with avm_burstcount = B and avm_address = wr_ptr (burst start address, constant for the whole burst). avm_writedata is the buffer head (copy) or fill_data (fill). The beat advances only when waitrequest = 0. avm_beginbursttransfer is high on the first write cycle only. After B accepted beats: remaining -= B, rd_ptr and wr_ptr += B*DATA_W/8. If remaining > 0, return to RD_CMD (copy) or WR_BURST (fill); otherwise go to FINISH.
  - FINISH: one cycle. busy goes to 0, done goes to 1, cycle_count freezes. Then return to IDLE.
- avm_read and avm_write are never high together. Command signals are stable while waitrequest = 1.
- cycle_count increments every cycle while busy, and saturates at 0xFFFFFFFF.
- start while busy is ignored, and latched values are unchanged. start in the same cycle as FINISH is ignored; it is accepted only in IDLE.
- Pointer addition wraps modulo 2^ADDR_W; bursts do not check for a wrap boundary.
- The final burst is partial when len is not a multiple of MAX_BURST.
- Latency: avm_read (copy) or avm_write (fill) rises on the second edge after the start edge, because IDLE goes to RD_CMD/WR_BURST and that state registers the request.

Test Plan:
1. Copy, src=0x0, dst=0x1000, len=8, MAX_BURST=8, zero-wait slave with data 0..7 -> one read burst (bc=8), one write burst (bc=8) at 0x1000 with data 0..7, done=1, busy=0.
2. Copy, len=19 -> bursts of 8, 8, 3; write addresses 0x1000, 0x1010, 0x1020; all 19 words match the source.
3. Fill, fill_data=0xA5A5, dst=0x200, len=5, random waitrequest -> no avm_read ever; 5 write beats of 0xA5A5; the command is held stable during every stall.
4. len=0 -> no bus activity; done=1 two cycles after start; cycle_count=1.
5. Second start while busy, then reset_reset_n=0 mid write burst -> the second start is ignored; after reset avm_write=0, done=0, busy=0, cycle_count=0 on the next edge.
6. dst=0xFFFFFFFC, len=4, DATA_W=16 -> burst address 0xFFFFFFFC; wr_ptr wraps to 0x00000004; done=1.
